// File: rtl/logic_unit_iter.sv
// Iterative bitwise logic unit (NOT/AND/OR/XOR): L result bits per cycle over N-bit operands.
// Latency N/L+1 cycles from the start edge back to idle; start is ignored while busy.
module logic_unit_iter #(
  parameter int N = 4,
  parameter int L = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic         Cin,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Y,
  output logic         zero
);

  localparam int NCH = N / L;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  if (N < 1 || L < 1 || L > N || (N % L) != 0) begin : g_bad_params
    $error("logic_unit_iter: illegal N/L combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]   op;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } opnd_t;

  state_t        state_q, state_d;
  opnd_t         opnd_q, opnd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  shadow_q, shadow_d;
  logic [N-1:0]  y_q, y_d;
  logic          zero_q, zero_d;
  logic [N-1:0]  res;
  logic [N-1:0]  merged;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opnd_q   <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      y_q      <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // Full-width function of the latched operands; only the current chunk is consumed.
  always_comb begin
    res = '0;
    case (opnd_q.op)
      2'b00: res = opnd_q.cin ? ~opnd_q.b : ~opnd_q.a;
      2'b01: res = opnd_q.a & opnd_q.b;
      2'b10: res = opnd_q.a | opnd_q.b;
      2'b11: res = opnd_q.a ^ opnd_q.b;
      default: res = '0;
    endcase
  end

  always_comb begin
    merged = shadow_q;
    for (int c = 0; c < NCH; c++) begin
      if (cnt_q == CW'(c)) merged[c*L +: L] = res[c*L +: L];
    end
  end

  always_comb begin
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    y_d      = y_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opnd_d.op  = op;
          opnd_d.cin = Cin;
          opnd_d.a   = A;
          opnd_d.b   = B;
          cnt_d      = '0;
          shadow_d   = '0;
        end
      end
      S_RUN: begin
        shadow_d = merged;
        if (cnt_q == LAST) begin
          y_d    = merged;
          zero_d = (merged == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign Y    = y_q;
  assign zero = zero_q;

  a_done_single: assert property (@(posedge clk) disable iff (rst) done |=> !done);
  a_done_busy:   assert property (@(posedge clk) done |-> busy);

endmodule

// File: doc/logic_unit_iter.md
# logic_unit_iter

Parametrised, iterative bitwise logic unit for the ALU datapath. It is the sequential successor of the single-function NOT stage and adds AND/OR/XOR modes. It processes L bits per clock over an N-bit operand pair under a start/done handshake. It holds the result and a zero flag in output registers until the next operation completes.

## Interface
- N, default 4: operand/result width in bits; N >= 1.
- L, default 1: bits processed per cycle (lane width); 1 <= L <= N, N % L == 0 (otherwise illegal, elaboration must fail).
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset (sampled on rising edge of clk).
- start  input  1  request; sampled only when unit is idle.
- op  input  2  operation: 00 NOT, 01 AND, 10 OR, 11 XOR.
- Cin  input  1  NOT operand select: 1 -> ~B, 0 -> ~A; ignored for other ops.
- A  input  N  operand A.
- B  input  N  operand B.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse: Y/zero just updated.
- Y  output  N  registered result; held between operations.
- zero  output  1  registered, 1 when Y == 0.

## Operation
- States: IDLE, RUN, DONE. Chunk counter cnt, width max(1, clog2(N/L)).
- IDLE: if start=1 at an edge, latch A, B, op, Cin into operand registers, set cnt=0, clear shadow result, go RUN. Otherwise stay.
- RUN: each edge computes result bits [cnt*L +: L] from the latched operands and writes them into the shadow result. Bits go LSB chunk first.
  - If cnt < N/L-1: cnt++ and stay in RUN.
  - If cnt == N/L-1: Y <= shadow with final chunk merged, zero <= (that value == 0), go DONE.
- DONE: done=1 for exactly this cycle. Next edge goes to IDLE unconditionally.
- Per-bit function: NOT: Cin ? ~B[i] : ~A[i]. AND: A[i]&B[i]. OR: A[i]|B[i]. XOR: A[i]^B[i].
- Operand inputs A/B/op/Cin may change freely after the start edge; the result uses only the latched values.
- Y and zero change only on the edge entering DONE. Partial results are never visible on Y.
- start is ignored while busy=1, including in the DONE cycle. A start held high is accepted on the first edge back in IDLE.
- rst=1 at any edge, including mid-RUN, forces: state IDLE, cnt=0, Y=0, zero=1, done=0, busy=0. Any in-flight operation is discarded and no done pulse is produced.
- rst has priority over start at the same edge.

## Timing
- Reset values: Y=0, zero=1, done=0, busy=0.
- With start accepted at edge k:
  - busy=1 from edge k to edge k+N/L+1.
  - Y/zero valid and done=1 from edge k+N/L to edge k+N/L+1.
  - Back in IDLE after edge k+N/L+1.
- Latency: N/L+1 cycles from start edge to idle. Throughput: one operation per N/L+2 cycles with start held high continuously (the IDLE cycle is mandatory).
- L=N: RUN lasts one cycle; done is asserted 1 cycle after the start edge.
- done is never high for two consecutive cycles.

## Test plan
- Reset mid-RUN (N=4, L=1): start AND at edge k, rst=1 at edge k+2 -> Y=0, zero=1, busy=0 from edge k+3. No done pulse follows, including in the 5 cycles after rst deasserts.
- NOT select (N=4, L=1): A=4'b1010, B=4'b0011, op=00. Cin=0 -> Y=4'b0101, done at edge k+4. Rerun with Cin=1 -> Y=4'b1100.
- All modes (N=8, L=2): A=8'hC5, B=8'h3A -> AND 8'h00 with zero=1, OR 8'hFF, XOR 8'hFF. done at edge k+4 each.
- Operand hold: during RUN, change A/B/op to random values each cycle -> Y equals the result from the start-edge values. Y keeps its prior value until the DONE edge.
- Busy rejection / back-to-back: hold start=1 continuously with L=1, N=4 -> starts accepted at edges k, k+6, k+12. Exactly one done pulse per op. A start pulse during DONE is not accepted.
- Single-cycle config (N=4, L=4): XOR A=4'hF, B=4'h0 -> Y=4'hF, zero=0, done at edge k+1, busy low at edge k+2.
